midi_hex_formatter: RTL

//   Hardware replacement for the PicoBlaze MIDI-to-hex TTY program. Buffers received MIDI bytes
//   in a FIFO and renders each one as two ASCII hex digits plus a separator on the TTY transmitter.

---
 rtl/midi_hex_formatter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/midi_hex_formatter.sv
// MIDI byte to ASCII hex TTY formatter: a FIFO buffers received bytes and a small FSM
// prints each one as two hex digits plus a separator, optionally preceded by CR/LF for status bytes.
module midi_hex_formatter #(
    parameter int          DEPTH           = 16,
    parameter bit          UPPERCASE       = 1'b1,
    parameter logic [7:0]  SEPARATOR       = 8'h20,
    parameter bit          STATUS_NEWLINE  = 1'b1,
    parameter bit          FILTER_REALTIME = 1'b0,
    parameter int          LED_HOLD        = 2500000,
    parameter int          CNT_W           = 8
) (
    input  logic                       clk50MHz,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_load,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       activity_led
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LED_HOLD + 1);

    typedef enum logic [2:0] {S_IDLE, S_CR, S_LF, S_HI, S_LO, S_SEP, S_WAIT} state_t;

    state_t           r_state, r_ret, w_state_nxt, w_ret_nxt;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_byte;
    logic [7:0]       r_tx_data;
    logic             r_tx_load;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drops;
    logic [LW-1:0]    r_led_cnt;
    logic             w_want_push, w_full, w_pop, w_push, w_drop, w_emit;
    logic [7:0]       w_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic is_status(input logic [7:0] b);
        return (b >= 8'h80) && (b < 8'hF8);
    endfunction

    function automatic state_t seq_next(input state_t s);
        case (s)
            S_CR:    return S_LF;
            S_LF:    return S_HI;
            S_HI:    return S_LO;
            S_LO:    return S_SEP;
            default: return S_IDLE;
        endcase
    endfunction

    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    assign w_want_push = rx_valid && !(FILTER_REALTIME && (rx_data >= 8'hF8));
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_push      = w_want_push && (!w_full || w_pop);
    assign w_drop      = w_want_push && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_emit      = 1'b0;
        w_char      = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_pop)
                    w_state_nxt = (STATUS_NEWLINE && is_status(r_mem[r_rd_ptr])) ? S_CR : S_HI;
            end
            S_CR, S_LF, S_HI, S_LO, S_SEP: begin
                if (tx_ready) begin
                    w_emit      = 1'b1;
                    w_ret_nxt   = seq_next(r_state);
                    w_state_nxt = S_WAIT;
                    case (r_state)
                        S_CR:    w_char = 8'h0D;
                        S_LF:    w_char = 8'h0A;
                        S_HI:    w_char = hex_char(r_byte[7:4]);
                        S_LO:    w_char = hex_char(r_byte[3:0]);
                        default: w_char = SEPARATOR;
                    endcase
                end
            end
            S_WAIT: begin
                if (!tx_ready)
                    w_state_nxt = r_ret;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk50MHz) begin
        if (w_push)
            r_mem[r_wr_ptr] <= rx_data;
        if (w_pop)
            r_byte <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ret      <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_data  <= 8'h00;
            r_tx_load  <= 1'b0;
            r_overflow <= 1'b0;
            r_drops    <= '0;
            r_led_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_tx_load <= w_emit;
            if (w_emit)
                r_tx_data <= w_char;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drops != '1)
                    r_drops <= r_drops + 1'b1;
            end
            if (w_push)
                r_led_cnt <= LW'(LED_HOLD);
            else if (r_led_cnt != '0)
                r_led_cnt <= r_led_cnt - 1'b1;
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_load      = r_tx_load;
    assign overflow     = r_overflow;
    assign drop_count   = r_drops;
    assign fifo_level   = r_count;
    assign activity_led = (r_led_cnt != '0);
endmodule
